sram_controller: RTL and testbench



---
 rtl/mem_pkg.sv | 11 +
 rtl/sram_controller_if.sv | 14 +
 rtl/sram_controller.sv | 109 ++++++++++
 tb/tb_sram_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default parameters for the SRAM memory-stage controller.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   localparam int unsigned WAIT_CYCLES_DEF = 3;
   localparam int unsigned BASE_ADDR_DEF   = 1024;
   localparam int unsigned SRAM_AW_DEF     = 18;
   localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/sram_controller_if.sv
// CPU-side memory-stage request/response bundle for sram_controller.
interface sram_controller_if;

   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        ready;

   modport master (output wr_en, rd_en, address, writeData, input readData, ready);
   modport slave  (input wr_en, rd_en, address, writeData, output readData, ready);

endinterface

// File: rtl/sram_controller.sv
// Memory-stage controller: each 32-bit access becomes two 16-bit SRAM transfers
// of WAIT_CYCLES clocks each; ready stays low until the access completes.
module sram_controller
   import mem_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
   parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
   input  logic               clk,
   input  logic               rst,
   sram_controller_if.slave   bus,
   inout  wire  [15:0]        SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] counter_nxt;
   logic             is_wr;
   logic [15:0]      wdata_hi;
   logic [15:0]      low_half;
   logic [15:0]      dq_out;
   logic             dq_oe;
   logic             req;
   logic             last;
   logic [31:0]      offset;
   logic             unused_offset;

   assign req         = bus.rd_en | bus.wr_en;
   assign offset      = bus.address - BASE_ADDR;
   assign last        = (counter == LAST);
   assign counter_nxt = CNT_W'(counter + 1'b1);
   assign bus.ready   = ~req | (state == DONE);
   assign SRAM_DQ     = dq_oe ? dq_out : 'z;

   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

   assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         counter      <= '0;
         is_wr        <= 1'b0;
         wdata_hi     <= '0;
         low_half     <= '0;
         dq_out       <= '0;
         dq_oe        <= 1'b0;
         SRAM_WE_N    <= 1'b1;
         SRAM_ADDR    <= '0;
         bus.readData <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state     <= LOW;
                  counter   <= '0;
                  is_wr     <= bus.wr_en;
                  wdata_hi  <= bus.writeData[31:16];
                  dq_out    <= bus.writeData[15:0];
                  dq_oe     <= bus.wr_en;
                  SRAM_WE_N <= ~bus.wr_en;
                  SRAM_ADDR <= {offset[SRAM_AW:2], 1'b0};
               end
            end
            LOW: begin
               if (last) begin
                  state     <= HIGH;
                  counter   <= '0;
                  dq_out    <= wdata_hi;
                  SRAM_WE_N <= ~is_wr;
                  SRAM_ADDR <= {SRAM_ADDR[SRAM_AW-1:1], 1'b1};
                  if (!is_wr) low_half <= SRAM_DQ;
               end else begin
                  // WE_N is registered, so it rises one cycle early relative to the count
                  counter   <= counter_nxt;
                  SRAM_WE_N <= ~is_wr | (counter_nxt == LAST);
               end
            end
            HIGH: begin
               if (last) begin
                  state     <= DONE;
                  counter   <= '0;
                  dq_oe     <= 1'b0;
                  SRAM_WE_N <= 1'b1;
                  if (!is_wr) bus.readData <= {SRAM_DQ, low_half};
               end else begin
                  counter   <= counter_nxt;
                  SRAM_WE_N <= ~is_wr | (counter_nxt == LAST);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: WAIT_CYCLES=3 and WAIT_CYCLES=2 instances
// each backed by a behavioral 256K x16 SRAM array.
module tb_sram_controller;
   import mem_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      int          lat;
      int          we_low;
      int          alo;
      int          gap;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   always @(posedge clk) cycle++;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   sram_controller_if if3 ();
   sram_controller_if if2 ();

   wire  [15:0] dq3, dq2;
   logic [17:0] a3, a2;
   logic        we3, we2;
   logic        ub3, lb3, ce3, oe3, ub2, lb2, ce2, oe2;

   sram_controller #(.WAIT_CYCLES(3), .BASE_ADDR(32'd1024), .SRAM_AW(18)) dut3 (
      .clk(clk), .rst(rst), .bus(if3.slave), .SRAM_DQ(dq3), .SRAM_ADDR(a3), .SRAM_WE_N(we3),
      .SRAM_UB_N(ub3), .SRAM_LB_N(lb3), .SRAM_CE_N(ce3), .SRAM_OE_N(oe3));

   sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024), .SRAM_AW(18)) dut2 (
      .clk(clk), .rst(rst), .bus(if2.slave), .SRAM_DQ(dq2), .SRAM_ADDR(a2), .SRAM_WE_N(we2),
      .SRAM_UB_N(ub2), .SRAM_LB_N(lb2), .SRAM_CE_N(ce2), .SRAM_OE_N(oe2));

   // Behavioral SRAMs: combinational read, write on rising WE_N
   logic [15:0] mem3 [0:262143];
   logic [15:0] mem2 [0:262143];
   assign dq3 = (if3.rd_en && !if3.wr_en) ? mem3[a3] : 'z;
   assign dq2 = (if2.rd_en && !if2.wr_en) ? mem2[a2] : 'z;
   always @(posedge we3) if (!rst) mem3[a3] = dq3;
   always @(posedge we2) if (!rst) mem2[a2] = dq2;

   exp_t q3[$];
   exp_t q2[$];
   int cyc3 = 0, wel3 = 0, alo3 = 0, ahi3 = 0, last3 = 0;
   int cyc2 = 0, wel2 = 0, alo2 = 0, ahi2 = 0, last2 = 0;
   int idle_we2 = 0, idle_nrdy2 = 0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         cyc3 = 0; wel3 = 0;
      end else if (if3.rd_en || if3.wr_en) begin
         if (cyc3 == 1) alo3 = int'(a3);
         if (cyc3 == 4) ahi3 = int'(a3);
         if (!we3) wel3++;
         if (if3.ready) begin
            if (q3.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_ready3: got ready at cycle %0d expected none", cycle);
            end else begin
               e = q3.pop_front();
               check("rdata3", 64'(if3.readData), 64'(e.rdata));
               check("latency3", 64'(cyc3), 64'(e.lat));
               check("we_low3", 64'(wel3), 64'(e.we_low));
               check("addr_lo3", 64'(alo3), 64'(e.alo));
               check("addr_hi3", 64'(ahi3), 64'(e.alo + 1));
               if (e.gap >= 0) check("gap3", 64'(cycle - last3), 64'(e.gap));
            end
            last3 = cycle; cyc3 = 0; wel3 = 0;
         end else cyc3++;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         cyc2 = 0; wel2 = 0;
      end else if (if2.rd_en || if2.wr_en) begin
         if (cyc2 == 1) alo2 = int'(a2);
         if (cyc2 == 3) ahi2 = int'(a2);
         if (!we2) wel2++;
         if (if2.ready) begin
            if (q2.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_ready2: got ready at cycle %0d expected none", cycle);
            end else begin
               e = q2.pop_front();
               check("rdata2", 64'(if2.readData), 64'(e.rdata));
               check("latency2", 64'(cyc2), 64'(e.lat));
               check("we_low2", 64'(wel2), 64'(e.we_low));
               check("addr_lo2", 64'(alo2), 64'(e.alo));
               check("addr_hi2", 64'(ahi2), 64'(e.alo + 1));
            end
            last2 = cycle; cyc2 = 0; wel2 = 0;
         end else cyc2++;
      end else begin
         if (!we2) idle_we2++;
         if (!if2.ready) idle_nrdy2++;
      end
   end

   task automatic acc(input int which, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] exp_rd, input int lat,
                      input int alo, input int gap);
      exp_t e;
      int   n;
      logic rdy;
      e.rdata  = exp_rd;
      e.lat    = lat;
      e.we_low = wr ? 2 * (lat / 2 - 1) : 0;
      e.alo    = alo;
      e.gap    = gap;
      if (which == 3) begin
         q3.push_back(e);
         if3.rd_en = rd; if3.wr_en = wr; if3.address = addr; if3.writeData = data;
      end else begin
         q2.push_back(e);
         if2.rd_en = rd; if2.wr_en = wr; if2.address = addr; if2.writeData = data;
      end
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         rdy = (which == 3) ? if3.ready : if2.ready;
      end while (!rdy && n < 40);
      if (!rdy) begin
         tests++; fails++;
         $display("FAIL timeout%0d: got no ready after %0d cycles expected ready", which, n);
      end
      @(posedge clk); #1;
      if (which == 3) begin if3.rd_en = 1'b0; if3.wr_en = 1'b0; end
      else begin if2.rd_en = 1'b0; if2.wr_en = 1'b0; end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin mem3[i] = '0; mem2[i] = '0; end
      if3.rd_en = 1'b0; if3.wr_en = 1'b0; if3.address = '0; if3.writeData = '0;
      if2.rd_en = 1'b0; if2.wr_en = 1'b0; if2.address = '0; if2.writeData = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(if3.ready), 64'd1);
      check("rst_we_n", 64'(we3), 64'd1);
      check("rst_rdata", 64'(if3.readData), 64'd0);
      check("rst_addr", 64'(a3), 64'd0);
      check("rst_dq_oe", 64'(dut3.dq_oe), 64'd0);
      check("tie_low", 64'({ub3, lb3, ce3, oe3, ub2, lb2, ce2, oe2}), 64'd0);
      rst = 1'b0;

      // Reset in the middle of a write: cycle 5 is HIGH with counter 1
      if3.wr_en = 1'b1; if3.address = 32'd1036; if3.writeData = 32'hCAFEF00D;
      repeat (5) @(posedge clk);
      #1;
      check("mid_state", 64'(dut3.state), 64'(HIGH));
      check("mid_counter", 64'(dut3.counter), 64'd1);
      rst = 1'b1; if3.wr_en = 1'b0;
      #1;
      check("mrst_state", 64'(dut3.state), 64'(IDLE));
      check("mrst_ready", 64'(if3.ready), 64'd1);
      check("mrst_we_n", 64'(we3), 64'd1);
      check("mrst_dq_oe", 64'(dut3.dq_oe), 64'd0);
      check("mrst_rdata", 64'(if3.readData), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      acc(3, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, 7, 0, -1);
      check("mem3_0", 64'(mem3[0]), 64'hBEEF);
      check("mem3_1", 64'(mem3[1]), 64'hDEAD);
      acc(3, 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 7, 0, -1);
      check("idle_after_read", 64'(dut3.state), 64'(IDLE));

      acc(3, 1'b0, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 7, 2, -1);
      acc(3, 1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678, 7, 2, 8);
      check("mem3_2", 64'(mem3[2]), 64'h5678);
      check("mem3_3", 64'(mem3[3]), 64'h1234);

      acc(3, 1'b1, 1'b1, 32'd1032, 32'h0000A5A5, 32'h12345678, 7, 4, -1);
      check("mem3_4", 64'(mem3[4]), 64'hA5A5);
      check("mem3_5", 64'(mem3[5]), 64'h0000);

      idle_we2 = 0; idle_nrdy2 = 0;
      repeat (10) @(posedge clk);
      #1;
      check("idle2_we_low", 64'(idle_we2), 64'd0);
      check("idle2_not_ready", 64'(idle_nrdy2), 64'd0);
      mem2[6] = 16'h1111; mem2[7] = 16'h2222;
      acc(2, 1'b1, 1'b0, 32'd1036, 32'h0, 32'h22221111, 5, 6, -1);

      repeat (3) @(posedge clk);
      #1;
      check("q3_drained", 64'(q3.size()), 64'd0);
      check("q2_drained", 64'(q2.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
